// File: rtl/ctrl_pipe_chain_if.sv
// rtl/ctrl_pipe_chain_if.sv - decode-to-pipeline control bundle handshake
interface ctrl_pipe_chain_if #(
    parameter int CW = 8
);
    logic          in_valid;
    logic [CW-1:0] in_ctrl;
    logic          in_ready;

    modport master (output in_valid, output in_ctrl, input in_ready);
    modport slave  (input in_valid, input in_ctrl, output in_ready);
endinterface

// File: rtl/ctrl_pipe_chain.sv
// rtl/ctrl_pipe_chain.sv - control bundle pipeline with per-stage valid, stall, flush and perf counters
module ctrl_pipe_chain #(
    parameter int CW     = 8,
    parameter int STAGES = 3,
    parameter int CNTW   = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    ctrl_pipe_chain_if.slave     up,
    input  logic [STAGES-1:0]    stall,
    input  logic [STAGES-1:0]    flush,
    input  logic                 cnt_clr,
    output logic [STAGES-1:0]    stage_valid,
    output logic [STAGES*CW-1:0] stage_ctrl,
    output logic                 retire,
    output logic [CNTW-1:0]      retire_cnt,
    output logic [CNTW-1:0]      stall_cnt,
    output logic [CNTW-1:0]      flush_cnt
);
    logic [STAGES-1:0] held;
    logic [STAGES-1:0] validQ;
    logic [STAGES-1:0] validNext;
    logic [CW-1:0]     ctrlQ    [STAGES];
    logic [CW-1:0]     ctrlNext [STAGES];
    logic [CNTW-1:0]   flushAdd;

    assign up.in_ready = ~held[0];
    assign stage_valid = validQ;
    assign retire      = validQ[STAGES-1] & ~stall[STAGES-1] & ~flush[STAGES-1];

    for (genvar g = 0; g < STAGES; g++) begin : g_stage
        // A stall anywhere downstream freezes this stage too.
        assign held[g] = |stall[STAGES-1:g];
        assign stage_ctrl[g*CW +: CW] = ctrlQ[g];

        always_comb begin
            validNext[g] = 1'b0;
            ctrlNext[g]  = '0;
            if (flush[g]) begin
                validNext[g] = 1'b0;
            end else if (held[g]) begin
                validNext[g] = validQ[g];
                ctrlNext[g]  = ctrlQ[g];
            end else begin
                if (g == 0) begin
                    validNext[g] = up.in_valid;
                    ctrlNext[g]  = up.in_valid ? up.in_ctrl : '0;
                end else if (!held[(g == 0) ? 0 : g-1]) begin
                    validNext[g] = validQ[(g == 0) ? 0 : g-1];
                    ctrlNext[g]  = ctrlQ[(g == 0) ? 0 : g-1];
                end
            end
        end

        always_ff @(posedge clk) begin
            if (!reset) begin
                validQ[g] <= 1'b0;
                ctrlQ[g]  <= '0;
            end else begin
                validQ[g] <= validNext[g];
                ctrlQ[g]  <= ctrlNext[g];
            end
        end
    end

    // Only entries that were actually valid count as killed.
    always_comb begin
        flushAdd = '0;
        for (int i = 0; i < STAGES; i++) begin
            flushAdd = flushAdd + CNTW'(flush[i] & validQ[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset || cnt_clr) begin
            retire_cnt <= '0;
            stall_cnt  <= '0;
            flush_cnt  <= '0;
        end else begin
            retire_cnt <= retire_cnt + CNTW'(retire);
            stall_cnt  <= stall_cnt + CNTW'(up.in_valid & ~up.in_ready);
            flush_cnt  <= flush_cnt + flushAdd;
        end
    end
endmodule

// File: tb/tb_ctrl_pipe_chain.sv
// tb/tb_ctrl_pipe_chain.sv - self-checking bench for ctrl_pipe_chain
module tb_ctrl_pipe_chain;
    localparam int CW   = 8;
    localparam int ST   = 3;
    localparam int CNTW = 4;
    localparam int CMOD = 1 << CNTW;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             reset;
    logic [ST-1:0]    stall, flush;
    logic             cnt_clr;
    logic [ST-1:0]    stage_valid;
    logic [ST*CW-1:0] stage_ctrl;
    logic             retire;
    logic [CNTW-1:0]  retire_cnt, stall_cnt, flush_cnt;

    ctrl_pipe_chain_if #(.CW(CW)) up ();

    ctrl_pipe_chain #(.CW(CW), .STAGES(ST), .CNTW(CNTW)) dut (
        .clk(clk), .reset(reset), .up(up.slave),
        .stall(stall), .flush(flush), .cnt_clr(cnt_clr),
        .stage_valid(stage_valid), .stage_ctrl(stage_ctrl), .retire(retire),
        .retire_cnt(retire_cnt), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    int compared = 0;
    int mismatched = 0;

    bit          mV [ST];
    logic [7:0]  mC [ST];
    int          mRet, mStl, mFl;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [CW-1:0] ctrlAt(input int i);
        logic [ST*CW-1:0] v;
        v = stage_ctrl;
        return v[i*CW +: CW];
    endfunction

    task automatic step(input bit rs, input bit iv, input logic [CW-1:0] ic,
                        input logic [ST-1:0] st, input logic [ST-1:0] fl, input bit clr);
        bit         hold [ST];
        bit         nV   [ST];
        logic [7:0] nC   [ST];
        bit         rdy, ret;
        int         killed;
        reset = rs; up.in_valid = iv; up.in_ctrl = ic;
        stall = st; flush = fl; cnt_clr = clr;
        #1;
        for (int i = 0; i < ST; i++) begin
            hold[i] = 1'b0;
            for (int j = i; j < ST; j++) if (st[j]) hold[i] = 1'b1;
        end
        rdy = !hold[0];
        ret = mV[ST-1] && !st[ST-1] && !fl[ST-1];
        chk("in_ready", 32'(up.in_ready), 32'(rdy));
        chk("retire", 32'(retire), 32'(ret));
        killed = 0;
        for (int i = 0; i < ST; i++) begin
            if (fl[i]) begin
                nV[i] = 0; nC[i] = 0;
                if (mV[i]) killed++;
            end else if (hold[i]) begin
                nV[i] = mV[i]; nC[i] = mC[i];
            end else if (i == 0) begin
                nV[i] = iv; nC[i] = iv ? ic : 8'h00;
            end else if (hold[i-1]) begin
                nV[i] = 0; nC[i] = 0;
            end else begin
                nV[i] = mV[i-1]; nC[i] = mC[i-1];
            end
        end
        if (!rs) begin
            for (int i = 0; i < ST; i++) begin nV[i] = 0; nC[i] = 0; end
            mRet = 0; mStl = 0; mFl = 0;
        end else if (clr) begin
            mRet = 0; mStl = 0; mFl = 0;
        end else begin
            mRet = (mRet + int'(ret)) % CMOD;
            mStl = (mStl + int'(iv && !rdy)) % CMOD;
            mFl  = (mFl + killed) % CMOD;
        end
        for (int i = 0; i < ST; i++) begin mV[i] = nV[i]; mC[i] = nC[i]; end
        @(posedge clk);
        #1;
        for (int i = 0; i < ST; i++) begin
            chk($sformatf("valid[%0d]", i), 32'(stage_valid[i]), 32'(mV[i]));
            chk($sformatf("ctrl[%0d]", i), 32'(ctrlAt(i)), 32'(mC[i]));
        end
        chk("retire_cnt", 32'(retire_cnt), 32'(mRet));
        chk("stall_cnt", 32'(stall_cnt), 32'(mStl));
        chk("flush_cnt", 32'(flush_cnt), 32'(mFl));
    endtask

    int fbefore;

    initial begin
        reset = 1'b0; up.in_valid = 1'b0; up.in_ctrl = '0;
        stall = '0; flush = '0; cnt_clr = 1'b0;
        for (int i = 0; i < ST; i++) begin mV[i] = 0; mC[i] = 0; end
        mRet = 0; mStl = 0; mFl = 0;
        @(posedge clk);
        #1;
        chk("rst_valid", 32'(stage_valid), 32'h0);
        chk("rst_ctrl", 32'(stage_ctrl), 32'h0);
        chk("rst_cnts", {20'h0, retire_cnt, stall_cnt, flush_cnt}, 32'h0);

        // Straight stream, then drain
        step(1, 1, 8'h11, 3'b000, 3'b000, 0);
        step(1, 1, 8'h22, 3'b000, 3'b000, 0);
        step(1, 1, 8'h33, 3'b000, 3'b000, 0);
        chk("t1_w_11", 32'(ctrlAt(2)), 32'h11);
        for (int k = 0; k < 3; k++) step(1, 0, 8'h00, 3'b000, 3'b000, 0);
        chk("t1_retire_cnt", 32'(retire_cnt), 32'd3);

        // Stall at E inserts bubbles into M
        step(1, 1, 8'h11, 3'b000, 3'b000, 0);
        step(1, 1, 8'h22, 3'b001, 3'b000, 0);
        chk("t2_m_bubble", 32'(stage_valid[1]), 32'd0);
        step(1, 1, 8'h22, 3'b001, 3'b000, 0);
        chk("t2_stall_cnt", 32'(stall_cnt), 32'd2);
        chk("t2_e_hold", 32'(ctrlAt(0)), 32'h11);
        step(1, 1, 8'h22, 3'b000, 3'b000, 0);
        chk("t2_e_22", 32'(ctrlAt(0)), 32'h22);

        // Stall at W freezes the whole chain
        step(1, 1, 8'hA3, 3'b000, 3'b000, 0);
        step(1, 1, 8'hA2, 3'b000, 3'b000, 0);
        step(1, 1, 8'hA1, 3'b000, 3'b000, 0);
        step(1, 1, 8'hB0, 3'b100, 3'b000, 0);
        chk("t3_w_hold", 32'(ctrlAt(2)), 32'hA3);
        step(1, 0, 8'h00, 3'b000, 3'b000, 0);
        chk("t3_w_a2", 32'(ctrlAt(2)), 32'hA2);

        // Flush beats stall; flushing an empty stage counts nothing
        step(1, 1, 8'h5A, 3'b000, 3'b000, 0);
        fbefore = int'(flush_cnt);
        step(1, 0, 8'h00, 3'b001, 3'b001, 0);
        chk("t4_e_killed", {23'h0, stage_valid[0], ctrlAt(0)}, 32'h0);
        chk("t4_flush_cnt", 32'(flush_cnt), 32'((fbefore + 1) % CMOD));
        step(1, 0, 8'h00, 3'b001, 3'b001, 0);
        chk("t4_flush_empty", 32'(flush_cnt), 32'((fbefore + 1) % CMOD));

        // Counter wrap with a 4-bit counter, then clear
        step(0, 0, 8'h00, 3'b000, 3'b000, 0);
        for (int k = 0; k < 20; k++) step(1, 1, CW'(k + 1), 3'b000, 3'b000, 0);
        chk("t5_wrap", 32'(retire_cnt), 32'd1);
        step(1, 1, 8'h40, 3'b000, 3'b000, 1);
        chk("t5_clr", {20'h0, retire_cnt, stall_cnt, flush_cnt}, 32'h0);

        // Reset mid-stall/flush with a full pipe, then immediate accept
        step(0, 1, 8'h77, 3'b111, 3'b111, 0);
        chk("t6_valid", 32'(stage_valid), 32'h0);
        chk("t6_ctrl", 32'(stage_ctrl), 32'h0);
        step(1, 1, 8'hC3, 3'b000, 3'b000, 0);
        chk("t6_accept", {23'h0, stage_valid[0], ctrlAt(0)}, 32'h1C3);

        // Randomized traffic against the reference model
        for (int k = 0; k < 400; k++) begin
            logic [ST-1:0] rs, rf;
            for (int i = 0; i < ST; i++) begin
                rs[i] = ($urandom_range(0, 5) == 0);
                rf[i] = ($urandom_range(0, 7) == 0);
            end
            step(($urandom_range(0, 60) != 0), 1'($urandom_range(0, 3) != 0),
                 CW'($urandom), rs, rf, ($urandom_range(0, 40) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/ctrl_pipe_chain.md
Name: ctrl_pipe_chain

Overview:
Parametrised control-signal pipeline that carries decoded control bundles from decode through STAGES register stages (E, M, W for the default 3).
Supersedes fixed per-stage flop chains: every stage has a valid bit, stall (hold) and flush, and bubble insertion.
Performance counters for retirements, input-stall cycles and flushed entries.
Sits between the main/ALU decoders and the datapath; the hazard unit drives stall/flush.

Parameters:
CW, 8, width of the control bundle per stage
STAGES, 3, number of register stages (>=2); index 0 = first stage after decode (E), STAGES-1 = last (W)
CNTW, 16, width of each performance counter

Ports:
clk  input  1  clock; all state updates on the rising edge
reset  input  1  synchronous, active-low reset
in_valid  input  1  decode stage holds a valid instruction
in_ctrl  input  CW  decoded control bundle
in_ready  output  1  stage 0 accepts in_ctrl this cycle
stall  input  STAGES  stall[i]=1: stage i must hold its content
flush  input  STAGES  flush[i]=1: stage i content is killed at the next edge
cnt_clr  input  1  synchronous clear of all counters
stage_valid  output  STAGES  valid bit of each stage
stage_ctrl  output  STAGES*CW  stage i bundle at bits [i*CW +: CW]
retire  output  1  combinational: last stage valid and not stalled
retire_cnt  output  CNTW  instructions retired
stall_cnt  output  CNTW  cycles with in_valid=1 and in_ready=0
flush_cnt  output  CNTW  valid entries killed by flush

Behaviour:
- Reset (reset=0 at edge): all stage_valid=0, all stage_ctrl=0, all counters=0. Reset overrides every other input, including mid-stall/flush.
- held[i] = OR of stall[STAGES-1:i]. A stalled stage freezes all earlier stages.
- in_ready = ~held[0], combinational.
- Next-state per stage i, in priority order:
  1. flush[i]: valid=0, ctrl=0. Flush beats hold.
  2. held[i]: keep valid and ctrl.
  3. i=0: valid=in_valid, ctrl = in_valid ? in_ctrl : 0.
  4. i>0, held[i-1]=1 (stall boundary): bubble, valid=0, ctrl=0.
  5. Otherwise: copy stage i-1 (valid and ctrl).
- Invalid stages always carry ctrl=0, so regwrite/memwrite bits in a bubble are inactive.
- Latency with no stall/flush: an instruction accepted at edge n appears in stage i after edge n+i. A stall of k cycles adds k.
- Input handshake: in_valid with in_ready=0 is not consumed. Upstream holds in_ctrl. No internal buffering.
- retire = stage_valid[STAGES-1] & ~stall[STAGES-1] & ~flush[STAGES-1].
- Counters (evaluated each edge; cnt_clr=1 zeroes all three and suppresses increments that cycle):
  - retire_cnt += retire.
  - stall_cnt += (in_valid & ~in_ready).
  - flush_cnt += popcount(flush & stage_valid), summed at CNTW bits.
  - All counters wrap modulo 2^CNTW; no saturation.
- Flush of an invalid stage has no effect and adds nothing to flush_cnt.
- Simultaneous stall[i] and flush[i]: stage i clears. Earlier stages stay held (held[] depends on stall only).

Test Plan:
1. STAGES=3, CW=8, stream 0x11,0x22,0x33 with in_valid=1 and no stall → stage_ctrl[W]=0x11 after edge 3, then 0x22, 0x33; retire=1 for three cycles; retire_cnt=3.
2. 0x11 in E, 0x22 at input, stall[0]=1 for 2 cycles → E holds 0x11; M receives bubbles (valid=0, ctrl=0x00); in_ready=0; stall_cnt=2; 0x22 enters E on the first non-stalled edge.
3. stall[2]=1 with E=0xA1, M=0xA2, W=0xA3 → all three stages hold; retire=0; in_ready=0; on release W=0xA2 next edge.
4. flush[0]=1 and stall[0]=1 with E=0x5A valid → E clears to valid=0, ctrl=0x00; flush_cnt=1. Same flush on an invalid E → flush_cnt unchanged.
5. CNTW=4 with 17 consecutive retires → retire_cnt=1 (wrap). Assert cnt_clr → all counters 0 next edge.
6. Pipeline full (E/M/W valid) and reset=0 for one edge with stall and flush active → all valid=0, ctrl=0, counters=0; reset=1 → accepts new input immediately.
